// File: rtl/async_fifo_frame_writer.sv
// Write-side frame producer for the async FIFO: buffers one {eop,data} word,
// drops whole frames when the FIFO is almost full at SOP, and counts frames.
module async_fifo_frame_writer #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  enable,
  input  logic                  clr_cnt,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH:0]   fifo_wr_data,
  input  logic                  fifo_full,
  input  logic                  fifo_afull,
  output logic [CNT_WIDTH-1:0]  frm_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  proto_err
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state_reg;
  logic                  buf_vld_reg;
  logic [DATA_WIDTH:0]   buf_reg;
  logic [CNT_WIDTH-1:0]  frm_cnt_reg;
  logic [CNT_WIDTH-1:0]  drop_cnt_reg;
  logic                  proto_err_reg;

  logic wr_fire;
  logic accept;
  logic load;
  logic drop_sop;
  logic frame_err;
  logic frm_done;

  assign wr_fire = buf_vld_reg & ~fifo_full;
  assign accept  = in_valid & in_ready;

  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      IDLE:    in_ready = enable & (~buf_vld_reg | wr_fire);
      PASS:    in_ready = ~buf_vld_reg | wr_fire;
      DROP:    in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Any accepted SOP re-runs the afull decision, even when it abandons a frame.
  assign drop_sop  = accept & in_sop & fifo_afull;
  assign load      = accept & (in_sop ? ~fifo_afull : (state_reg == PASS));
  assign frame_err = accept & ((state_reg == IDLE) ? ~in_sop : in_sop);
  assign frm_done  = wr_fire & buf_reg[DATA_WIDTH];

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_reg   <= IDLE;
      buf_vld_reg <= 1'b0;
      buf_reg     <= '0;
    end else begin
      if (accept) begin
        if (in_eop)
          state_reg <= IDLE;
        else if (in_sop)
          state_reg <= fifo_afull ? DROP : PASS;
      end
      if (load) begin
        buf_vld_reg <= 1'b1;
        buf_reg     <= {in_eop, in_data};
      end else if (wr_fire) begin
        buf_vld_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      frm_cnt_reg   <= '0;
      drop_cnt_reg  <= '0;
      proto_err_reg <= 1'b0;
    end else if (clr_cnt) begin
      frm_cnt_reg   <= '0;
      drop_cnt_reg  <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      if (frm_done && frm_cnt_reg != CNT_MAX)
        frm_cnt_reg <= frm_cnt_reg + 1'b1;
      if (drop_sop && drop_cnt_reg != CNT_MAX)
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      if (frame_err)
        proto_err_reg <= 1'b1;
    end
  end

  assign fifo_wr_en   = wr_fire;
  assign fifo_wr_data = buf_reg;
  assign frm_cnt      = frm_cnt_reg;
  assign drop_cnt     = drop_cnt_reg;
  assign proto_err    = proto_err_reg;

endmodule
